// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered 8x8 signed multiplier among NUM_REQ clients.
// Optional overflow flag output res_ovf enabled by defining MULT_ARB_OVF_EN.

module multiplier_8bit (
    input  logic              clk,
    input  logic signed [7:0] x,
    input  logic signed [7:0] y,
    output logic signed [15:0] z
);
    // Registered full-width product; intentionally unreset, consumers gate it with valid.
    always_ff @(posedge clk) begin
        z <= x * y;
    end
endmodule

module mult_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 cclk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] x_bus,
    input  logic [8*NUM_REQ-1:0] y_bus,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [15:0]          res_z,
`ifdef MULT_ARB_OVF_EN
    output logic                 res_ovf,
`endif
    output logic                 busy
);
    localparam int unsigned OP_W = 8;
    localparam int unsigned Z_W  = 16;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state, state_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic                valid_n, busy_n, grant, any;
    logic [ID_W-1:0]     id_n, last, last_n, win, cand;
    logic signed [OP_W-1:0] op_x, op_y, opx_n, opy_n, sel_x, sel_y;
    logic signed [Z_W-1:0]  z;
    int                  idx;

    multiplier_8bit u_mul (
        .clk (cclk),
        .x   (op_x),
        .y   (op_y),
        .z   (z)
    );

    // Round-robin search starting just after the last winner, plus its operand mux.
    always_comb begin
        any   = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        sel_x = '0;
        sel_y = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = int'(last) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            cand = ID_W'(idx);
            if (!any && req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win == ID_W'(i)) begin
                sel_x = x_bus[i*OP_W +: OP_W];
                sel_y = y_bus[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = '0;
        valid_n = res_valid;
        id_n    = res_id;
        opx_n   = op_x;
        opy_n   = op_y;
        last_n  = last;
        grant   = 1'b0;
        case (state)
            IDLE: grant = any;
            MUL: begin
                state_n = DONE;
                valid_n = 1'b1;
            end
            DONE: begin
                if (res_ready) begin
                    grant   = any;
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (grant) begin
            state_n = MUL;
            valid_n = 1'b0;
            gnt_n   = NUM_REQ'(1) << win;
            opx_n   = sel_x;
            opy_n   = sel_y;
            id_n    = win;
            last_n  = win;
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            op_x      <= '0;
            op_y      <= '0;
            last      <= ID_W'(NUM_REQ - 1);
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            res_valid <= valid_n;
            res_id    <= id_n;
            op_x      <= opx_n;
            op_y      <= opy_n;
            last      <= last_n;
            busy      <= busy_n;
        end
    end

    // The unreset multiplier output is only exposed while a result is valid.
    assign res_z = res_valid ? Z_W'(z) : 16'h0000;

`ifdef MULT_ARB_OVF_EN
    assign res_ovf = res_valid && !((&z[15:7]) || !(|z[15:7]));
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus a randomized run against a transaction model.
// Build with MULT_ARB_OVF_EN defined to also exercise res_ovf.

module tb_mult_arbiter;
    logic        cclk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] x_bus, y_bus;
    logic [3:0]  gnt;
    logic        res_valid, res_ready, busy;
    logic [1:0]  res_id;
    logic [15:0] res_z;
`ifdef MULT_ARB_OVF_EN
    logic        res_ovf;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] xs [4];
    logic [7:0] ys [4];

    mult_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .cclk(cclk), .rst(rst), .req(req), .x_bus(x_bus), .y_bus(y_bus),
        .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_z(res_z),
`ifdef MULT_ARB_OVF_EN
        .res_ovf(res_ovf),
`endif
        .busy(busy)
    );

    always #5 cclk = ~cclk;

    task automatic step;
        @(posedge cclk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] i, input logic [7:0] a, input logic [7:0] b);
        xs[i] = a;
        ys[i] = b;
        x_bus = {xs[3], xs[2], xs[1], xs[0]};
        y_bus = {ys[3], ys[2], ys[1], ys[0]};
    endtask

    // Reference rules: next winner after lst in circular order; full signed product.
    function automatic int pick(input logic [3:0] r, input int lst);
        int i;
        for (int k = 1; k <= 4; k++) begin
            i = (lst + k) % 4;
            if (r[2'(i)]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    task automatic test_reset;
        for (int i = 0; i < 4; i++) set_op(2'(i), 8'h00, 8'h00);
        rst = 1'b1; req = 4'h0; res_ready = 1'b0;
        step; step;
        checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt got=%h want=0", gnt); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d want=0", res_id); end
        checks++; if (res_z !== 16'h0) begin errors++; $display("FAIL reset_z got=%h want=0000", res_z); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef MULT_ARB_OVF_EN
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", res_ovf); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single;
        set_op(2'd0, 8'd7, 8'hFD);
        req = 4'b0001; res_ready = 1'b0;
        step;
        checks++; if (gnt !== 4'b0001 || busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL single_grant gnt=%b busy=%b valid=%b want 0001/1/0", gnt, busy, res_valid); end
        req = 4'b0000;
        step;
        checks++; if (gnt !== 4'b0 || res_valid !== 1'b1 || res_z !== 16'hFFEB || res_id !== 2'd0) begin
            errors++; $display("FAIL single_result gnt=%b valid=%b z=%h id=%0d want 0000/1/ffeb/0", gnt, res_valid, res_z, res_id); end
        step;
        checks++; if (res_valid !== 1'b1 || res_z !== 16'hFFEB) begin
            errors++; $display("FAIL single_hold valid=%b z=%h want 1/ffeb", res_valid, res_z); end
        res_ready = 1'b1;
        step;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_z !== 16'h0) begin
            errors++; $display("FAIL single_idle valid=%b busy=%b z=%h want 0/0/0000", res_valid, busy, res_z); end
    endtask

    task automatic test_contention;
        int ng, nr, last_cyc, gi;
        rst = 1'b1; step; rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(2'(i), 8'($urandom), 8'($urandom));
        req = 4'b1111; res_ready = 1'b1;
        ng = 0; nr = 0; last_cyc = 0;
        for (int c = 0; c < 30 && nr < 4; c++) begin
            step;
            if (gnt !== 4'b0) begin
                gi = -1;
                for (int i = 0; i < 4; i++) if (gnt[2'(i)]) gi = i;
                checks++; if (gnt !== 4'(1 << ng)) begin errors++; $display("FAIL cont_order gnt=%b want=%b", gnt, 4'(1 << ng)); end
                if (gi >= 0) req[2'(gi)] = 1'b0;
                ng++;
            end
            if (res_valid === 1'b1) begin
                checks++; if (res_id !== 2'(nr) || res_z !== prod(xs[2'(nr)], ys[2'(nr)])) begin
                    errors++; $display("FAIL cont_result id=%0d z=%h want %0d/%h", res_id, res_z, nr, prod(xs[2'(nr)], ys[2'(nr)])); end
                if (nr > 0) begin
                    checks++; if (c - last_cyc != 2) begin errors++; $display("FAIL cont_spacing got=%0d want=2", c - last_cyc); end
                end
                last_cyc = c; nr++;
            end
        end
        checks++; if (nr != 4) begin errors++; $display("FAIL cont_timeout results=%0d want=4", nr); end
        req = 4'b0; step;
    endtask

    task automatic test_wrap;
        res_ready = 1'b1;
        req = 4'b1000; step;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_g3 gnt=%b want=1000", gnt); end
        req = 4'b0000; step;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd3) begin errors++; $display("FAIL wrap_r3 valid=%b id=%0d want 1/3", res_valid, res_id); end
        req = 4'b1001; step;
        checks++; if (gnt !== 4'b0001 || res_valid !== 1'b0) begin errors++; $display("FAIL wrap_g0 gnt=%b valid=%b want 0001/0", gnt, res_valid); end
        req = 4'b1000; step;
        checks++; if (res_id !== 2'd0 || res_valid !== 1'b1) begin errors++; $display("FAIL wrap_r0 id=%0d valid=%b want 0/1", res_id, res_valid); end
        step;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_g3b gnt=%b want=1000", gnt); end
        req = 4'b0000; step; step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle busy=%b want=0", busy); end
    endtask

    task automatic test_backpressure;
        set_op(2'd2, 8'h80, 8'h80); set_op(2'd0, 8'd3, 8'd4); set_op(2'd1, 8'hFF, 8'hFF);
        req = 4'b0100; res_ready = 1'b0; step;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL bp_grant gnt=%b want=0100", gnt); end
        req = 4'b0000; step;
        checks++; if (res_valid !== 1'b1 || res_z !== 16'h4000 || res_id !== 2'd2) begin
            errors++; $display("FAIL bp_result valid=%b z=%h id=%0d want 1/4000/2", res_valid, res_z, res_id); end
        req = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            step;
            checks++; if (gnt !== 4'b0 || res_valid !== 1'b1 || res_z !== 16'h4000 || res_id !== 2'd2) begin
                errors++; $display("FAIL bp_stall gnt=%b valid=%b z=%h id=%0d want 0000/1/4000/2", gnt, res_valid, res_z, res_id); end
        end
        res_ready = 1'b1; step;
        checks++; if (gnt !== 4'b0001 || res_valid !== 1'b0) begin errors++; $display("FAIL bp_release gnt=%b valid=%b want 0001/0", gnt, res_valid); end
        req = 4'b0010; step;
        checks++; if (res_z !== 16'h000C || res_id !== 2'd0) begin errors++; $display("FAIL bp_r0 z=%h id=%0d want 000c/0", res_z, res_id); end
        step;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_g1 gnt=%b want=0010", gnt); end
        req = 4'b0000; step;
        checks++; if (res_z !== 16'h0001 || res_id !== 2'd1) begin errors++; $display("FAIL bp_r1 z=%h id=%0d want 0001/1", res_z, res_id); end
        step;
    endtask

    task automatic test_reset_midop;
        res_ready = 1'b1;
        req = 4'b0010; step;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_grant gnt=%b want=0010", gnt); end
        rst = 1'b1; req = 4'b0000; step;
        checks++; if (gnt !== 4'b0 || res_valid !== 1'b0 || res_z !== 16'h0 || busy !== 1'b0 || res_id !== 2'd0) begin
            errors++; $display("FAIL rmid_clear gnt=%b valid=%b z=%h busy=%b id=%0d want all 0", gnt, res_valid, res_z, busy, res_id); end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step;
            checks++; if (res_valid !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rmid_quiet valid=%b gnt=%b busy=%b want 0/0000/0", res_valid, gnt, busy); end
        end
        req = 4'b0101; step;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_next gnt=%b want=0001", gnt); end
        rst = 1'b1; req = 4'b0000; step; rst = 1'b0;
    endtask

`ifdef MULT_ARB_OVF_EN
    task automatic test_ovf;
        res_ready = 1'b1;
        set_op(2'd0, 8'd100, 8'd2); req = 4'b0001; step;
        req = 4'b0000; step;
        checks++; if (res_z !== 16'd200 || res_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos z=%h ovf=%b want 00c8/1", res_z, res_ovf); end
        set_op(2'd1, 8'hF0, 8'd8); req = 4'b0010; step;
        req = 4'b0000; step;
        checks++; if (res_z !== 16'hFF80 || res_ovf !== 1'b0) begin errors++; $display("FAIL ovf_neg z=%h ovf=%b want ff80/0", res_z, res_ovf); end
        step;
    endtask
`endif

    // Transaction model: at most one result in flight; grants only when free or on an accepting edge.
    task automatic test_random;
        int mlast, g, age, nres;
        logic outst, exp_g, exp_v, v_prev, rdy_prev;
        logic [3:0] req_prev;
        logic [15:0] ez;
        logic [1:0] eid;
        rst = 1'b1; req = 4'b0; res_ready = 1'b0; step; rst = 1'b0;
        mlast = 3; outst = 1'b0; age = 0; nres = 0; ez = '0; eid = '0;
        v_prev = 1'b0; rdy_prev = 1'b0; req_prev = 4'b0;
        for (int c = 0; c < 800; c++) begin
            step;
            if (v_prev && rdy_prev) begin outst = 1'b0; nres++; end
            exp_g = (req_prev != 4'b0) && !outst;
            checks++; if ((gnt != 4'b0) !== exp_g) begin errors++; $display("FAIL rnd_gnt_timing cyc=%0d gnt=%b want_grant=%b", c, gnt, exp_g); end
            g = -1;
            if (exp_g) begin
                g = pick(req_prev, mlast);
                checks++; if (gnt !== 4'(1 << g)) begin errors++; $display("FAIL rnd_winner cyc=%0d gnt=%b want=%b", c, gnt, 4'(1 << g)); end
                outst = 1'b1; age = 0; mlast = g;
                ez = prod(xs[2'(g)], ys[2'(g)]); eid = 2'(g);
                req[2'(g)] = 1'b0;
            end else if (outst) begin
                age++;
            end
            exp_v = outst && (age >= 1);
            checks++; if (res_valid !== exp_v || res_z !== (exp_v ? ez : 16'h0) || (exp_v && res_id !== eid)) begin
                errors++; $display("FAIL rnd_result cyc=%0d valid=%b z=%h id=%0d want %b/%h/%0d", c, res_valid, res_z, res_id, exp_v, exp_v ? ez : 16'h0, eid); end
`ifdef MULT_ARB_OVF_EN
            checks++; if (res_ovf !== (exp_v && ($signed(ez) > 127 || $signed(ez) < -128))) begin
                errors++; $display("FAIL rnd_ovf cyc=%0d ovf=%b z=%h", c, res_ovf, ez); end
`endif
            for (int i = 0; i < 4; i++) begin
                if (!req[2'(i)] && i != g && $urandom_range(3) == 0) begin
                    set_op(2'(i), 8'($urandom), 8'($urandom));
                    req[2'(i)] = 1'b1;
                end
            end
            res_ready = ($urandom_range(2) != 0);
            req_prev = req; rdy_prev = res_ready; v_prev = exp_v;
        end
        checks++; if (nres < 50) begin errors++; $display("FAIL rnd_progress results=%0d want>=50", nres); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_wrap;
        test_backpressure;
        test_reset_midop;
`ifdef MULT_ARB_OVF_EN
        test_ovf;
`endif
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
